fir_sample_feeder: RTL and testbench
====================================

Name: fir_sample_feeder

Overview:
Upstream stage of the FIR filter. Accepts signed 16-bit PCM samples over a valid/ready stream and converts each to IEEE-754 single precision (exact, no rounding). Buffers converted words in a small FIFO and presents one word at a time on the filter's 32-bit sample input, advancing on each filter `next` request. Drives the filter's `stop` input once the end-of-stream sample has been consumed.

Parameters:
DEPTH, 16, FIFO depth in 32-bit words; power of two, minimum 4
IN_W, 16, input sample width, signed two's complement; range 2..24, so conversion is always exact

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
s_valid  input  1  upstream sample valid
s_data  input  IN_W  signed PCM sample
s_last  input  1  marks the final sample of the stream; qualified by s_valid
s_ready  output  1  feeder can accept a sample this cycle
next  input  1  filter request; each 0->1 edge requests a fresh sample
fir_in  output  32  float32 sample presented to the filter
fir_in_valid  output  1  fir_in holds a presented, not yet superseded sample
fir_stop  output  1  end of stream reached; drives the filter's stop
underrun  output  1  sticky; a request arrived with no data available

Behaviour:
- Reset, asynchronous: fir_in=0, fir_in_valid=0, fir_stop=0, underrun=0, s_ready=0 while rst=0. FIFO is emptied, the pipeline is cleared, next_q=1 so a held-high next does not count as an edge. State=IDLE. Reset mid-stream discards all buffered samples.
- Input accept: a transfer occurs when s_valid && s_ready. s_ready = (fifo_count + in-flight pipeline entries) < DEPTH. This reserves space for the words still in the converter.
- Conversion pipeline, 2 stages, one sample per cycle:
  - S1 registers sign, |x| (IN_W bits, unsigned, so -2^(IN_W-1) fits) and the leading-one position; the last flag travels alongside.
  - S2 normalises. Exponent = 127 + position. Mantissa = bits below the leading one, left-justified in 23 bits. Zero maps to 0x00000000.
  - Result plus last bit is written to the FIFO 2 cycles after the accept.
- FIFO: 33 bits wide (word + last). Push and pop may happen in the same cycle. A pop while empty never happens.
- Request detect: req = next && !next_q, with next_q registered every cycle.
- FSM:
  - IDLE: nothing presented. If the FIFO is non-empty, pop, load fir_in, set fir_in_valid=1, go to HOLD.
  - HOLD: on req, if the presented word had last=1, set fir_stop=1 and go to DONE. Otherwise, if the FIFO is non-empty, pop and load fir_in the next edge and stay in HOLD. Otherwise clear fir_in_valid, set underrun=1 and go to WAIT.
  - WAIT: when the FIFO becomes non-empty, pop, load fir_in, set fir_in_valid=1, go to HOLD. Further reqs while in WAIT are absorbed; no queueing of requests.
  - DONE: fir_stop stays 1, fir_in and fir_in_valid are held, s_ready=0. Exit only by reset.
- Latency: fir_in updates 1 cycle after the req edge when data is available.
- Simultaneous req and FIFO push while empty, in HOLD: go to WAIT. Data appears on the following cycle.
- fir_in is stable at all times except on the cycle after a pop.

Decomposition:
- Shared package fir_pkg:
  - float32 field constants: FP_BIAS=127, FP_MANT_W=23, FP_EXP_W=8.
  - feeder state enum {IDLE, HOLD, WAIT, DONE}.
  - typedef fifo_entry_t {logic last; logic [31:0] word}.
- One natural sub-module: int_to_fp, the 2-stage converter with valid/last sideband.
- The FIFO is inline; the team's generic sync_fifo may be substituted.

Test Plan:
- Conversion values: push 1, -1, 0, 100, 32767, -32768 and pulse next between each. Required fir_in sequence: 0x3F800000, 0xBF800000, 0x00000000, 0x42C80000, 0x46FFFE00, 0xC7000000.
- Backpressure: hold s_valid=1 with no next edges after the first load. s_ready falls after exactly DEPTH accepted samples beyond the presented one. No sample is lost or duplicated after subsequent draining.
- Underrun: present one sample, give a next edge with the FIFO empty. fir_in_valid=0 and underrun=1. Push 5; 3 cycles later fir_in=0x40A00000 and fir_in_valid=1; underrun stays 1.
- End of stream: push 3 samples, the last with s_last=1, and give 3 next edges. After the 3rd edge, fir_stop=1 one cycle later and s_ready=0. fir_in holds the third value.
- Level next: hold next=1 for 6 cycles. The FIFO pops exactly once.
- Async reset mid-stream: drop rst with 4 words buffered. Outputs clear immediately with no clock edge. After release, the first pushed sample 2 appears as 0x40000000.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample feeder.
//   FP_BIAS / FP_MANT_W / FP_EXP_W : float32 field constants
//   feeder_state_t                 : presentation FSM states
//   fifo_entry_t                   : buffered float32 word plus end-of-stream flag
package fir_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT,
    DONE
  } feeder_state_t;

  typedef struct packed {
    logic        last;
    logic [31:0] word;
  } fifo_entry_t;

endpackage

// File: rtl/fir_sample_feeder_if.sv
// Stream and filter-side signals of the FIR sample feeder.
//   s_valid/s_data/s_last/s_ready : upstream PCM sample stream (valid/ready)
//   next                          : filter request, rising edge asks for a sample
//   fir_in/fir_in_valid           : float32 sample presented to the filter
//   fir_stop                      : end of stream reached
//   underrun                      : sticky, a request found no data
// slave  = feeder view, master = upstream/filter view.
interface fir_sample_feeder_if #(
  parameter int IN_W = 16
);
  logic                   s_valid;
  logic signed [IN_W-1:0] s_data;
  logic                   s_last;
  logic                   s_ready;
  logic                   next;
  logic [31:0]            fir_in;
  logic                   fir_in_valid;
  logic                   fir_stop;
  logic                   underrun;

  modport slave (
    input  s_valid, s_data, s_last, next,
    output s_ready, fir_in, fir_in_valid, fir_stop, underrun
  );

  modport master (
    output s_valid, s_data, s_last, next,
    input  s_ready, fir_in, fir_in_valid, fir_stop, underrun
  );
endinterface

// File: rtl/int_to_fp.sv
// Two-stage signed integer to float32 converter, exact for IN_W <= 24.
//   clk, rst     : clock, asynchronous active-low reset (clears valids only)
//   i_vld/i_data/i_last : sample in, one per cycle
//   o_vld/o_word/o_last : converted word, two cycles after input
//   o_inflight   : number of samples currently held in the two stages
module int_to_fp
  import fir_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_vld,
  input  logic signed [IN_W-1:0] i_data,
  input  logic                   i_last,
  output logic                   o_vld,
  output logic [31:0]            o_word,
  output logic                   o_last,
  output logic [1:0]             o_inflight
);

  localparam int POS_W = 5;

  function automatic logic [POS_W-1:0] lead_one(input logic [IN_W-1:0] m);
    lead_one = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (m[i]) lead_one = POS_W'(i);
    end
  endfunction

  // Bits below the leading one are shifted up so the leading one lands on
  // the hidden-bit position (bit 23) and falls off the 23-bit mantissa.
  function automatic logic [31:0] normalise(input logic             sign,
                                            input logic [IN_W-1:0]  mag,
                                            input logic [POS_W-1:0] pos);
    logic [23:0]           m24;
    logic [FP_MANT_W-1:0]  mant;
    logic [FP_EXP_W-1:0]   expo;
    m24  = 24'(mag);
    mant = FP_MANT_W'(m24 << (5'd23 - pos));
    expo = FP_EXP_W'(FP_BIAS) + FP_EXP_W'(pos);
    if (mag == '0) normalise = '0;
    else           normalise = {sign, expo, mant};
  endfunction

  logic [IN_W-1:0] w_data_u;
  logic [IN_W-1:0] w_mag;

  // Unsigned magnitude: -2^(IN_W-1) becomes 2^(IN_W-1), which still fits.
  assign w_data_u = i_data;
  assign w_mag    = w_data_u[IN_W-1] ? (~w_data_u + IN_W'(1)) : w_data_u;

  // Stage p1: sign, magnitude, leading-one position
  logic             r_vld_p1;
  logic             r_sign_p1;
  logic [IN_W-1:0]  r_mag_p1;
  logic [POS_W-1:0] r_pos_p1;
  logic             r_last_p1;

  // Stage p2: normalised float32 word
  logic             r_vld_p2;
  logic [31:0]      r_word_p2;
  logic             r_last_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= i_vld;
      r_vld_p2 <= r_vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    r_sign_p1 <= w_data_u[IN_W-1];
    r_mag_p1  <= w_mag;
    r_pos_p1  <= lead_one(w_mag);
    r_last_p1 <= i_last;
    r_word_p2 <= normalise(r_sign_p1, r_mag_p1, r_pos_p1);
    r_last_p2 <= r_last_p1;
  end

  assign o_vld      = r_vld_p2;
  assign o_word     = r_word_p2;
  assign o_last     = r_last_p2;
  assign o_inflight = {1'b0, r_vld_p1} + {1'b0, r_vld_p2};

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds float32 samples to the FIR filter.
//   clk : rising-edge clock
//   rst : asynchronous reset, active-low
//   bus : fir_sample_feeder_if.slave -- upstream PCM stream in, filter
//         sample/request/stop/underrun out
// PCM samples are converted to float32, buffered in a DEPTH-word FIFO and
// presented one at a time, advancing on each rising edge of next.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IN_W  = 16
) (
  input logic                 clk,
  input logic                 rst,
  fir_sample_feeder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic        w_accept;
  logic        w_s_ready;
  logic        w_cv_vld;
  logic [31:0] w_cv_word;
  logic        w_cv_last;
  logic [1:0]  w_inflight;

  // Words still in the converter count against FIFO space so nothing
  // accepted can ever find the FIFO full when it arrives.
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  fifo_entry_t   r_mem [DEPTH];
  fifo_entry_t   w_head;
  logic          w_empty;
  logic          w_pop;

  feeder_state_t r_state;
  feeder_state_t w_state_nx;
  logic [31:0]   r_fir_in;
  logic          r_fir_in_valid;
  logic          r_fir_stop;
  logic          r_underrun;
  logic          r_cur_last;
  logic          r_next_q;
  logic          w_req;
  logic          w_valid_nx;
  logic          w_stop_nx;
  logic          w_underrun_nx;

  assign w_s_ready = rst && (r_state != DONE) &&
                     (({1'b0, r_count} + (AW+2)'(w_inflight)) < (AW+2)'(DEPTH));
  assign w_accept  = bus.s_valid && w_s_ready;

  int_to_fp #(.IN_W(IN_W)) u_conv (
    .clk        (clk),
    .rst        (rst),
    .i_vld      (w_accept),
    .i_data     (bus.s_data),
    .i_last     (bus.s_last),
    .o_vld      (w_cv_vld),
    .o_word     (w_cv_word),
    .o_last     (w_cv_last),
    .o_inflight (w_inflight)
  );

  // FIFO
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_cv_vld) r_mem[r_wr_ptr] <= '{last: w_cv_last, word: w_cv_word};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_cv_vld) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_cv_vld, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Only a 0->1 transition of next is a request; reset primes next_q high
  // so a next that is already high when reset ends is not an edge.
  assign w_req = bus.next && !r_next_q;

  always_comb begin
    w_state_nx    = r_state;
    w_pop         = 1'b0;
    w_valid_nx    = r_fir_in_valid;
    w_stop_nx     = r_fir_stop;
    w_underrun_nx = r_underrun;
    case (r_state)
      IDLE, WAIT: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_valid_nx = 1'b1;
          w_state_nx = HOLD;
        end
      end
      HOLD: begin
        if (w_req) begin
          if (r_cur_last) begin
            w_stop_nx  = 1'b1;
            w_state_nx = DONE;
          end else if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_valid_nx    = 1'b0;
            w_underrun_nx = 1'b1;
            w_state_nx    = WAIT;
          end
        end
      end
      DONE: begin
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_fir_in       <= '0;
      r_fir_in_valid <= 1'b0;
      r_fir_stop     <= 1'b0;
      r_underrun     <= 1'b0;
      r_cur_last     <= 1'b0;
      r_next_q       <= 1'b1;
    end else begin
      r_state        <= w_state_nx;
      r_fir_in_valid <= w_valid_nx;
      r_fir_stop     <= w_stop_nx;
      r_underrun     <= w_underrun_nx;
      r_next_q       <= bus.next;
      if (w_pop) begin
        r_fir_in   <= w_head.word;
        r_cur_last <= w_head.last;
      end
    end
  end

  assign bus.s_ready      = w_s_ready;
  assign bus.fir_in       = r_fir_in;
  assign bus.fir_in_valid = r_fir_in_valid;
  assign bus.fir_stop     = r_fir_stop;
  assign bus.underrun     = r_underrun;

endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;

  localparam int DEPTH = 16;
  localparam int IN_W  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_sample_feeder_if #(.IN_W(IN_W)) bus ();

  fir_sample_feeder #(.DEPTH(DEPTH), .IN_W(IN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic signed [15:0] din;
    logic [31:0]        expw;
  } conv_vec_t;
  conv_vec_t vecs [11];

  logic [31:0] exp_q [$];
  logic        prev_next_b;
  logic        prev_valid_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, expv);
    end
  endtask

  // Reference conversion through the double-precision encoding: for integers
  // of at most 24 bits the top 23 fraction bits are the exact float32 mantissa.
  function automatic logic [31:0] ref_fp(input int v);
    real         r;
    logic [63:0] d;
    int          e;
    if (v == 0) return 32'h0;
    r = v;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.next    = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic push(input int v, input logic last);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'(v);
    bus.s_last  = last;
    chk1("push_ready", bus.s_ready, 1'b1);
    step();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Returns just after the edge at which the request is seen.
  task automatic pulse();
    bus.next = 1'b0;
    step();
    bus.next = 1'b1;
    step();
    bus.next = 1'b0;
  endtask

  // Random-phase cycle: records accepted samples, then after the edge checks
  // every newly presented word against the head of the expected queue.
  task automatic rstep();
    logic acc;
    logic req;
    acc = bus.s_valid && bus.s_ready;
    req = bus.next && !prev_next_b;
    if (acc) exp_q.push_back(ref_fp(int'(bus.s_data)));
    step();
    prev_next_b = bus.next;
    if (bus.fir_in_valid && (!prev_valid_b || req)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rand_extra: presented %h, required no new word", bus.fir_in);
      end else begin
        chk("rand_word", bus.fir_in, exp_q.pop_front());
      end
    end
    prev_valid_b = bus.fir_in_valid;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n_acc;
    int n;
    logic acc;

    vecs[0]  = '{16'sd1,      32'h3F800000};
    vecs[1]  = '{-16'sd1,     32'hBF800000};
    vecs[2]  = '{16'sd0,      32'h00000000};
    vecs[3]  = '{16'sd100,    32'h42C80000};
    vecs[4]  = '{16'sd32767,  32'h46FFFE00};
    vecs[5]  = '{-16'sd32768, 32'hC7000000};
    vecs[6]  = '{16'sd2,      32'h40000000};
    vecs[7]  = '{16'sd5,      32'h40A00000};
    vecs[8]  = '{-16'sd3,     32'hC0400000};
    vecs[9]  = '{16'sd1024,   32'h44800000};
    vecs[10] = '{16'sd255,    32'h437F0000};

    // Reset state, before any clock edge
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.next    = 1'b0;
    #1;
    chk("rst_fir_in", bus.fir_in, 32'h0);
    chk1("rst_valid", bus.fir_in_valid, 1'b0);
    chk1("rst_stop", bus.fir_stop, 1'b0);
    chk1("rst_underrun", bus.underrun, 1'b0);
    chk1("rst_s_ready", bus.s_ready, 1'b0);
    do_reset();
    chk1("post_rst_s_ready", bus.s_ready, 1'b1);
    chk1("post_rst_valid", bus.fir_in_valid, 1'b0);

    // Conversion table
    for (int i = 0; i < 11; i++) push(int'(vecs[i].din), 1'b0);
    repeat (3) step();
    chk("conv[0]", bus.fir_in, vecs[0].expw);
    chk1("conv_valid", bus.fir_in_valid, 1'b1);
    for (int i = 1; i < 11; i++) begin
      pulse();
      chk($sformatf("conv[%0d]", i), bus.fir_in, vecs[i].expw);
    end

    // Backpressure: DEPTH samples beyond the presented one, then stall
    do_reset();
    n_acc       = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'(1);
    for (int c = 0; c < 60; c++) begin
      acc = bus.s_ready;
      step();
      if (acc) begin
        n_acc++;
        bus.s_data = 16'(n_acc + 1);
      end
    end
    chk("bp_accepted", 32'(n_acc), 32'(DEPTH + 1));
    chk1("bp_ready_low", bus.s_ready, 1'b0);
    bus.s_valid = 1'b0;
    chk("bp_first", bus.fir_in, ref_fp(1));
    for (int k = 2; k <= DEPTH + 1; k++) begin
      pulse();
      chk($sformatf("bp_drain[%0d]", k), bus.fir_in, ref_fp(k));
    end
    pulse();
    chk1("bp_end_valid", bus.fir_in_valid, 1'b0);
    chk1("bp_end_underrun", bus.underrun, 1'b1);

    // Underrun and recovery
    do_reset();
    push(7, 1'b0);
    repeat (3) step();
    chk("un_first", bus.fir_in, ref_fp(7));
    chk1("un_no_underrun", bus.underrun, 1'b0);
    pulse();
    chk1("un_valid", bus.fir_in_valid, 1'b0);
    chk1("un_underrun", bus.underrun, 1'b1);
    push(5, 1'b0);
    repeat (2) step();
    chk1("un_wait_valid", bus.fir_in_valid, 1'b0);
    step();
    chk("un_recover_word", bus.fir_in, 32'h40A00000);
    chk1("un_recover_valid", bus.fir_in_valid, 1'b1);
    chk1("un_sticky", bus.underrun, 1'b1);

    // End of stream
    do_reset();
    push(10, 1'b0);
    push(20, 1'b0);
    push(30, 1'b1);
    repeat (3) step();
    chk("eos_w0", bus.fir_in, ref_fp(10));
    pulse();
    chk("eos_w1", bus.fir_in, ref_fp(20));
    pulse();
    chk("eos_w2", bus.fir_in, ref_fp(30));
    chk1("eos_stop_early", bus.fir_stop, 1'b0);
    pulse();
    chk1("eos_stop", bus.fir_stop, 1'b1);
    chk1("eos_s_ready", bus.s_ready, 1'b0);
    chk("eos_hold", bus.fir_in, ref_fp(30));
    chk1("eos_valid", bus.fir_in_valid, 1'b1);

    // Level next pops once
    do_reset();
    push(1, 1'b0);
    push(2, 1'b0);
    push(3, 1'b0);
    repeat (3) step();
    chk("lvl_w0", bus.fir_in, ref_fp(1));
    bus.next = 1'b1;
    repeat (6) step();
    bus.next = 1'b0;
    chk("lvl_once", bus.fir_in, ref_fp(2));
    pulse();
    chk("lvl_next", bus.fir_in, ref_fp(3));

    // Asynchronous reset with four words buffered
    do_reset();
    for (int i = 11; i <= 15; i++) push(i, 1'b0);
    repeat (4) step();
    chk("ar_before", bus.fir_in, ref_fp(11));
    #3;
    rst = 1'b0;
    #1;
    chk("ar_fir_in", bus.fir_in, 32'h0);
    chk1("ar_valid", bus.fir_in_valid, 1'b0);
    chk1("ar_stop", bus.fir_stop, 1'b0);
    chk1("ar_underrun", bus.underrun, 1'b0);
    chk1("ar_s_ready", bus.s_ready, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    step();
    push(2, 1'b0);
    repeat (3) step();
    chk("ar_after", bus.fir_in, 32'h40000000);
    chk1("ar_after_valid", bus.fir_in_valid, 1'b1);
    pulse();
    chk1("ar_discarded", bus.underrun, 1'b1);

    // Randomised stream against the queue model
    do_reset();
    exp_q.delete();
    prev_next_b  = 1'b0;
    prev_valid_b = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.s_data  = 16'($urandom);
      bus.s_last  = 1'b0;
      bus.next    = ($urandom_range(0, 2) == 0);
      rstep();
    end
    bus.s_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      bus.next = n[0];
      rstep();
      n++;
    end
    chk("rand_drain_left", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
